// File: rtl/qif_spike_analyzer.sv
// Spike analyzer for the QIF neuron: counts rising edges of spike_in over a programmable
// window and reports the last inter-spike interval. Define QIF_ANALYZER_MINISI_EN to also track the minimum ISI.
module qif_spike_analyzer #(
    parameter int WIN_W = 16,
    parameter int CNT_W = 8,
    parameter int ISI_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             spike_in,
    input  logic [WIN_W-1:0] win_len,
    input  logic             start,
    input  logic             stop,
    input  logic             cont,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic [ISI_W-1:0] out_isi,
    output logic [ISI_W-1:0] out_min_isi,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_REPORT} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_spike_prev;
    logic [WIN_W-1:0] r_win_len;
    logic [WIN_W-1:0] r_win_rem;
    logic             r_cont;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic [ISI_W-1:0] r_timer;
    logic [ISI_W-1:0] r_last_isi;
    logic             r_first_seen;

    logic             w_event;
    logic             w_measure;
    logic             w_start_acc;
    logic             w_clear;
    logic             w_win_last;
    logic [WIN_W-1:0] w_len_eff;
    logic [CNT_W-1:0] w_count_inc;

    function automatic logic [CNT_W-1:0] f_sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [ISI_W-1:0] f_sat_inc_isi(input logic [ISI_W-1:0] v);
        return (v == '1) ? v : v + ISI_W'(1);
    endfunction

    // Edge detection runs regardless of ena so re-enabling never creates a false edge.
    assign w_event     = spike_in & ~r_spike_prev & ena;
    assign w_measure   = ena & (r_state == S_MEASURE);
    assign w_start_acc = ena & (r_state == S_IDLE) & start;
    assign w_clear     = w_start_acc | (ena & (r_state == S_REPORT) & out_ready & r_cont);
    assign w_win_last  = (r_win_rem == WIN_W'(1));
    assign w_len_eff   = (win_len == '0) ? WIN_W'(1) : win_len;
    assign w_count_inc = f_sat_inc_cnt(r_count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_spike_prev <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_spike_prev <= spike_in;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (ena) begin
            case (r_state)
                S_IDLE:    if (start) w_state_nxt = S_MEASURE;
                S_MEASURE: begin
                    if (stop)            w_state_nxt = S_IDLE;
                    else if (w_win_last) w_state_nxt = S_REPORT;
                end
                S_REPORT:  if (out_ready) w_state_nxt = r_cont ? S_MEASURE : S_IDLE;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        out_valid = 1'b0;
        busy      = 1'b0;
        if (r_state == S_REPORT) out_valid = 1'b1;
        if (r_state != S_IDLE)   busy      = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_len    <= '0;
            r_win_rem    <= '0;
            r_cont       <= 1'b0;
            r_count      <= '0;
            r_ovf        <= 1'b0;
            r_timer      <= '0;
            r_last_isi   <= '0;
            r_first_seen <= 1'b0;
        end else if (w_clear) begin
            if (w_start_acc) begin
                r_win_len <= w_len_eff;
                r_win_rem <= w_len_eff;
                r_cont    <= cont;
            end else begin
                r_win_rem <= r_win_len;
            end
            r_count      <= '0;
            r_ovf        <= 1'b0;
            r_timer      <= '0;
            r_last_isi   <= '0;
            r_first_seen <= 1'b0;
        end else if (w_measure) begin
            if (!w_win_last) r_win_rem <= r_win_rem - WIN_W'(1);
            // Timer restarts at 1 on each event so the next event captures the edge distance.
            r_timer <= w_event ? ISI_W'(1) : f_sat_inc_isi(r_timer);
            if (w_event) begin
                r_count      <= w_count_inc;
                r_ovf        <= r_ovf | (w_count_inc == '1);
                r_first_seen <= 1'b1;
                if (r_first_seen) r_last_isi <= r_timer;
            end
        end
    end

`ifdef QIF_ANALYZER_MINISI_EN
    logic [ISI_W-1:0] r_min_isi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_min_isi <= '0;
        end else if (w_clear) begin
            r_min_isi <= '1;
        end else if (w_measure && w_event && r_first_seen && (r_timer < r_min_isi)) begin
            r_min_isi <= r_timer;
        end
    end

    assign out_min_isi = (r_count > CNT_W'(1)) ? r_min_isi : '0;
`else
    assign out_min_isi = '0;
`endif

    assign out_count = r_count;
    assign out_isi   = r_last_isi;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_qif_spike_analyzer.sv
// Directed bench for qif_spike_analyzer: table of single-shot windows plus hand-written
// sequences for reset, saturation, continuous mode, stop and async reset.
module tb_qif_spike_analyzer;
    localparam int WIN_W = 16;
    localparam int CNT_W = 8;
    localparam int ISI_W = 12;
`ifdef QIF_ANALYZER_MINISI_EN
    localparam bit MINISI = 1'b1;
`else
    localparam bit MINISI = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ena = 1'b0;
    logic             spike_in = 1'b0;
    logic [WIN_W-1:0] win_len = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             cont = 1'b0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [CNT_W-1:0] out_count;
    logic [ISI_W-1:0] out_isi;
    logic [ISI_W-1:0] out_min_isi;
    logic             overflow;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    qif_spike_analyzer #(.WIN_W(WIN_W), .CNT_W(CNT_W), .ISI_W(ISI_W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .spike_in(spike_in), .win_len(win_len),
        .start(start), .stop(stop), .cont(cont), .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .out_isi(out_isi), .out_min_isi(out_min_isi),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int e0, e1, e2, e3;
        int cnt, isi, mn;
    } vec_t;
    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drives window edges lo..hi, with one-cycle spike pulses rising on the listed edges.
    task automatic run_edges(input int lo, input int hi, input int e0, input int e1,
                             input int e2, input int e3);
        for (int k = lo; k <= hi; k++) begin
            spike_in = (k == e0) || (k == e1) || (k == e2) || (k == e3);
            tick();
        end
        spike_in = 1'b0;
    endtask

    task automatic do_start(input int len, input logic c);
        win_len = len[WIN_W-1:0];
        cont    = c;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic check_result(input string tag, input int cnt, input int isi, input int mn,
                                input int ovf);
        chk({tag, " valid"}, int'(out_valid), 1);
        chk({tag, " busy"}, int'(busy), 1);
        chk({tag, " count"}, int'(out_count), cnt);
        chk({tag, " isi"}, int'(out_isi), isi);
        chk({tag, " min_isi"}, int'(out_min_isi), MINISI ? mn : 0);
        chk({tag, " overflow"}, int'(overflow), ovf);
    endtask

    initial begin
        vecs[0] = '{len: 20, e0: 3,  e1: 8,  e2: 15, e3: -1, cnt: 3, isi: 7, mn: 5};
        vecs[1] = '{len: 0,  e0: 1,  e1: -1, e2: -1, e3: -1, cnt: 1, isi: 0, mn: 0};
        vecs[2] = '{len: 20, e0: 2,  e1: 10, e2: 13, e3: 20, cnt: 4, isi: 7, mn: 3};
        vecs[3] = '{len: 10, e0: -1, e1: -1, e2: -1, e3: -1, cnt: 0, isi: 0, mn: 0};
        vecs[4] = '{len: 5,  e0: 1,  e1: 5,  e2: -1, e3: -1, cnt: 2, isi: 4, mn: 4};

        // Reset with spike high: everything zero.
        ena      = 1'b1;
        spike_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst valid", int'(out_valid), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst count", int'(out_count), 0);
        chk("rst isi", int'(out_isi), 0);
        chk("rst min_isi", int'(out_min_isi), 0);
        chk("rst overflow", int'(overflow), 0);
        rst_n = 1'b1;
        tick();
        tick();

        // start while ena=0 is ignored.
        ena   = 1'b0;
        start = 1'b1;
        tick();
        chk("start ena0 busy", int'(busy), 0);
        start = 1'b0;
        ena   = 1'b1;

        // spike held high since reset release: no edge in the window.
        do_start(5, 1'b0);
        repeat (5) tick();
        check_result("held spike", 0, 0, 0, 0);
        spike_in = 1'b0;
        handshake();
        chk("held spike idle", int'(busy), 0);

        for (int i = 0; i < 5; i++) begin
            automatic int n = (vecs[i].len == 0) ? 1 : vecs[i].len;
            automatic string tag = $sformatf("vec%0d", i);
            do_start(vecs[i].len, 1'b0);
            chk({tag, " busy start"}, int'(busy), 1);
            run_edges(1, n - 1, vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3);
            chk({tag, " not early"}, int'(out_valid), 0);
            run_edges(n, n, vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3);
            check_result(tag, vecs[i].cnt, vecs[i].isi, vecs[i].mn, 0);
            repeat (5) tick();
            chk({tag, " held valid"}, int'(out_valid), 1);
            chk({tag, " held count"}, int'(out_count), vecs[i].cnt);
            handshake();
            chk({tag, " done valid"}, int'(out_valid), 0);
            chk({tag, " done busy"}, int'(busy), 0);
        end

        // Saturation: spike toggles every cycle, 300 rising edges in 600 cycles.
        do_start(600, 1'b0);
        for (int k = 1; k <= 600; k++) begin
            spike_in = (k % 2) == 1;
            tick();
        end
        spike_in = 1'b0;
        check_result("saturate", 255, 2, 2, 1);
        handshake();

        // Continuous mode: three back-to-back windows.
        do_start(10, 1'b1);
        run_edges(1, 10, 3, -1, -1, -1);
        check_result("cont w1", 1, 0, 0, 0);
        out_ready = 1'b1;
        spike_in  = 1'b1;
        tick();
        out_ready = 1'b0;
        spike_in  = 1'b0;
        chk("cont hs valid", int'(out_valid), 0);
        chk("cont hs busy", int'(busy), 1);
        run_edges(1, 10, -1, -1, -1, -1);
        check_result("cont w2", 0, 0, 0, 0);
        handshake();
        run_edges(1, 10, 2, 6, -1, -1);
        check_result("cont w3", 2, 4, 4, 0);
        handshake();

        // Stop mid-window discards the measurement; start during MEASURE is ignored.
        start = 1'b1;
        run_edges(1, 5, 2, -1, -1, -1);
        start = 1'b0;
        stop  = 1'b1;
        tick();
        stop  = 1'b0;
        chk("stop valid", int'(out_valid), 0);
        chk("stop busy", int'(busy), 0);
        repeat (12) tick();
        chk("stop no result", int'(out_valid), 0);
        do_start(10, 1'b0);
        run_edges(1, 10, 4, -1, -1, -1);
        check_result("after stop", 1, 0, 0, 0);
        handshake();

        // Asynchronous reset mid-window.
        do_start(10, 1'b0);
        run_edges(1, 3, 2, -1, -1, -1);
        chk("pre-reset count", int'(out_count), 1);
        rst_n = 1'b0;
        #1;
        chk("async rst busy", int'(busy), 0);
        chk("async rst count", int'(out_count), 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
